cp0_register_file: RTL and testbench
====================================

Name: cp0_register_file

Overview:
- Coprocessor 0 register storage: the producer of the cp0_status / cp0_cause / cp0_epc values that the memory-access stage consumes and forwards.
- Absorbs MTC0 writes from write-back, exception entry and ERET from the exception handler, hardware interrupts, and the Count/Compare timer.
- Sits beside the register file and exposes one combinational MFC0 read port.

Parameters:
- DATA_WIDTH, 32, register width; only 32 is supported.
- STATUS_RESET, 32'h0040_0000, Status value on reset (BEV=1).
- STATUS_WMASK, 32'h0040_FF03, software-writable Status bits: BEV, IM[7:0], EXL, IE.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- wb_wb_cp0  in  1  MTC0 write enable from WB, `REG_WB = write.
- wb_cp0_write_addr  in  `CP0_REG_BUS (5)  MTC0 target register.
- wb_cp0_write  in  32  MTC0 data.
- cp0_read_addr  in  5  MFC0 source register.
- cp0_read_data  out  32  MFC0 data; combinational.
- exc_valid  in  1  exception commit this cycle.
- exc_code  in  5  ExcCode.
- exc_pc  in  32  PC of the faulting instruction.
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot.
- exc_bad_vaddr  in  32  faulting address; used for AdEL/AdES.
- eret  in  1  ERET commit this cycle.
- hw_int  in  6  external interrupt lines, level-sensitive.
- cp0_status, cp0_cause, cp0_epc, cp0_count, cp0_compare, cp0_bad_vaddr  out  32 each  registered contents.
- timer_int  out  1  timer interrupt pending.

Behaviour:
- Reset (rst=1 at posedge):
  - Status = STATUS_RESET.
  - All other registers = 0.
  - timer_int = 0.
  - Reset overrides every other input in that cycle.
- Register addresses:
  - BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14.
  - cp0_read_data returns the current registered value; any other address reads 0.
  - No internal write-to-read bypass; forwarding is done downstream.
- MTC0 (wb_wb_cp0=1), takes effect at the next edge:
  - Status: new = (old & ~STATUS_WMASK) | (data & STATUS_WMASK).
  - Cause: only bits 9:8 (IP1:0), 22 (WP) and 23 (IV) are written.
  - EPC, Count, Compare, BadVAddr: full 32-bit write.
  - Unimplemented addresses: ignored.
- Count:
  - Increments by 1 every cycle; wraps 0xFFFF_FFFF -> 0.
  - An MTC0 to Count loads the written value; there is no increment in that cycle.
- Timer:
  - When Count == Compare and Compare != 0, pending is set at the next edge.
  - Pending is sticky until an MTC0 to Compare, which clears it (the clear wins over a same-cycle match).
  - timer_int = pending.
- Cause interrupt bits, updated every cycle:
  - Cause[14:10] (IP6:2) = hw_int[4:0], sampled.
  - Cause[15] (IP7) = hw_int[5] | pending.
  - These bits are read-only to MTC0.
- Exception entry (exc_valid=1):
  - If Status.EXL == 0: EPC = exc_in_delay_slot ? exc_pc - 4 : exc_pc, and Cause[31] (BD) = exc_in_delay_slot.
  - If EXL is already 1: EPC and BD are unchanged.
  - Always: Status.EXL = 1 and Cause[6:2] = exc_code.
  - If exc_code is AdEL (4) or AdES (5): BadVAddr = exc_bad_vaddr.
- ERET (eret=1, exc_valid=0): Status.EXL = 0. If exc_valid and eret are both high, the exception wins and ERET is ignored.
- MTC0 in the same cycle as an exception:
  - The MTC0 is applied first.
  - Exception-written fields (EXL, ExcCode, BD, EPC, BadVAddr) override the same fields.
  - Bits the exception does not touch keep the MTC0 value.
- All outputs except cp0_read_data are registered, with 1-cycle latency from any input.

Decomposition:
- defines.v holds:
  - CP0_REG_* addresses, including the existing CP0_REG_STATUS, CP0_REG_CAUSE and CP0_REG_EPC.
  - EXC_* codes: INT 0, ADEL 4, ADES 5, SYS 8, BP 9, RI 10, OV 12.
  - Status/Cause bit-position constants (EXL, IE, BD, IP7).
  - The Cause write mask 32'h00C0_0300.
- One sub-module, cp0_timer, holds Count, Compare, pending, load-on-write and wrap.

Test Plan:
- Reset, then 10 idle cycles -> Status 0x0040_0000, Count 10, Cause 0, EPC 0, timer_int 0.
- MTC0 Status 0xFFFF_FFFF -> Status 0x0040_FF03. MTC0 Cause 0xFFFF_FFFF -> Cause 0x00C0_0300. MFC0 addr 12 / 13 returns these; addr 3 returns 0.
- Timer:
  - MTC0 Compare 0x20, MTC0 Count 0x1E -> timer_int rises 3 cycles later (Count matches 0x20 after 2 increments, pending registers at the next edge) and Cause[15] = 1.
  - timer_int stays high while Count passes 0x21+.
  - MTC0 Compare 0x40 -> timer_int 0 on the next edge.
- Exception, exc_code 4, pc 0xBFC0_0100, delay slot 1, bad_vaddr 0x1233 -> EPC 0xBFC0_00FC, Cause BD = 1, Cause[6:2] = 4, BadVAddr 0x1233, EXL = 1.
  - A second exception (code 12, pc 0x8000_0000) leaves EPC and BD unchanged and sets ExcCode 12.
  - ERET -> EXL 0.
- Simultaneous: MTC0 EPC 0x1234 with exc_valid (EXL=0, pc 0x400) -> EPC 0x400. exc_valid with eret -> EXL stays 1.
- Wrap and priority:
  - MTC0 Count 0xFFFF_FFFF -> Count 0 one cycle later.
  - hw_int = 6'b100001 -> Cause[15:10] = 6'b100001 next cycle.
  - Asserting rst mid-run returns all registers to reset values at the next edge.

Source files
------------

// File: rtl/cp0_register_file_pkg.sv
// CP0 register addresses, exception codes and Status/Cause bit positions shared by the CP0 block.
// No state or timing of its own.
package cp0_register_file_pkg;

    localparam int CP0_REG_W = 5;

    localparam logic [CP0_REG_W-1:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [CP0_REG_W-1:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [CP0_REG_W-1:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [CP0_REG_W-1:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [CP0_REG_W-1:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [CP0_REG_W-1:0] CP0_REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP2    = 10;
    localparam int CAUSE_IP6    = 14;
    localparam int CAUSE_IP7    = 15;
    localparam int CAUSE_BD     = 31;

    // IP1:0, WP and IV are the only software-writable Cause bits.
    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_register_file_if.sv
// Pipeline-facing CP0 bundle: MTC0/MFC0, exception/ERET commit, interrupts and register outputs.
// Pure wiring; no flow control, every input is consumed in the cycle it is presented.
interface cp0_register_file_if;

    logic        wb_wb_cp0;
    logic [4:0]  wb_cp0_write_addr;
    logic [31:0] wb_cp0_write;
    logic [4:0]  cp0_read_addr;
    logic [31:0] cp0_read_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_bad_vaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_count;
    logic [31:0] cp0_compare;
    logic [31:0] cp0_bad_vaddr;
    logic        timer_int;

    modport master (
        output wb_wb_cp0, wb_cp0_write_addr, wb_cp0_write, cp0_read_addr,
        output exc_valid, exc_code, exc_pc, exc_in_delay_slot, exc_bad_vaddr,
        output eret, hw_int,
        input  cp0_read_data, cp0_status, cp0_cause, cp0_epc,
        input  cp0_count, cp0_compare, cp0_bad_vaddr, timer_int
    );

    modport slave (
        input  wb_wb_cp0, wb_cp0_write_addr, wb_cp0_write, cp0_read_addr,
        input  exc_valid, exc_code, exc_pc, exc_in_delay_slot, exc_bad_vaddr,
        input  eret, hw_int,
        output cp0_read_data, cp0_status, cp0_cause, cp0_epc,
        output cp0_count, cp0_compare, cp0_bad_vaddr, timer_int
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky match pending; Count free-runs and wraps, MTC0 loads override the increment.
// One-cycle latency from writes to registers; pending_nxt exposes the value the pending flop will take.
module cp0_timer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_we,
    input  logic                  compare_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0] compare,
    output logic                  pending,
    output logic                  pending_nxt
);

    logic match;

    // A zero Compare is treated as "timer disarmed" so reset state never fires.
    assign match = (count == compare) && (compare != '0);

    always_comb begin
        pending_nxt = pending | match;
        if (compare_we) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            pending <= 1'b0;
        end else begin
            count   <= count_we ? wdata : count + DATA_WIDTH'(1);
            if (compare_we) begin
                compare <= wdata;
            end
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/cp0_register_file.sv
// CP0 storage: Status/Cause/EPC/BadVAddr plus timer, updated by MTC0, exceptions, ERET and interrupts.
// Registered outputs with 1-cycle latency, combinational MFC0 read; never stalls its producers.
module cp0_register_file
    import cp0_register_file_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
    parameter logic [31:0] STATUS_WMASK = 32'h0040_FF03
) (
    input  logic              clk,
    input  logic              rst,
    cp0_register_file_if.slave bus
);

    logic [DATA_WIDTH-1:0] status_q, status_nxt;
    logic [DATA_WIDTH-1:0] cause_q, cause_nxt;
    logic [DATA_WIDTH-1:0] epc_q, epc_nxt;
    logic [DATA_WIDTH-1:0] badv_q, badv_nxt;
    logic [DATA_WIDTH-1:0] count, compare;
    logic                  pending, pending_nxt;
    logic                  wr_status, wr_cause, wr_epc, wr_badv, wr_count, wr_compare;
    logic                  is_adel_ades;

    assign wr_status  = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == CP0_REG_STATUS);
    assign wr_cause   = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == CP0_REG_CAUSE);
    assign wr_epc     = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == CP0_REG_EPC);
    assign wr_badv    = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == CP0_REG_BADVADDR);
    assign wr_count   = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == CP0_REG_COUNT);
    assign wr_compare = bus.wb_wb_cp0 && (bus.wb_cp0_write_addr == CP0_REG_COMPARE);

    assign is_adel_ades = (bus.exc_code == EXC_ADEL) || (bus.exc_code == EXC_ADES);

    cp0_timer #(.DATA_WIDTH(DATA_WIDTH)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_we    (wr_count),
        .compare_we  (wr_compare),
        .wdata       (bus.wb_cp0_write),
        .count       (count),
        .compare     (compare),
        .pending     (pending),
        .pending_nxt (pending_nxt)
    );

    // MTC0 is applied first; exception/ERET then override only the fields they own.
    always_comb begin
        status_nxt = status_q;
        cause_nxt  = cause_q;
        epc_nxt    = epc_q;
        badv_nxt   = badv_q;

        if (wr_status) status_nxt = masked_write(status_q, bus.wb_cp0_write, STATUS_WMASK);
        if (wr_cause)  cause_nxt  = masked_write(cause_q, bus.wb_cp0_write, CAUSE_WMASK);
        if (wr_epc)    epc_nxt    = bus.wb_cp0_write;
        if (wr_badv)   badv_nxt   = bus.wb_cp0_write;

        cause_nxt[CAUSE_IP6:CAUSE_IP2] = bus.hw_int[4:0];
        cause_nxt[CAUSE_IP7]           = bus.hw_int[5] | pending_nxt;

        if (bus.exc_valid) begin
            // Nested exceptions keep the original return point.
            if (!status_q[STATUS_EXL]) begin
                epc_nxt            = bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
                cause_nxt[CAUSE_BD] = bus.exc_in_delay_slot;
            end
            status_nxt[STATUS_EXL]                = 1'b1;
            cause_nxt[CAUSE_EXC_HI:CAUSE_EXC_LO] = bus.exc_code;
            if (is_adel_ades) begin
                badv_nxt = bus.exc_bad_vaddr;
            end
        end else if (bus.eret) begin
            status_nxt[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RESET;
            cause_q  <= '0;
            epc_q    <= '0;
            badv_q   <= '0;
        end else begin
            status_q <= status_nxt;
            cause_q  <= cause_nxt;
            epc_q    <= epc_nxt;
            badv_q   <= badv_nxt;
        end
    end

    always_comb begin
        bus.cp0_read_data = '0;
        case (bus.cp0_read_addr)
            CP0_REG_BADVADDR: bus.cp0_read_data = badv_q;
            CP0_REG_COUNT:    bus.cp0_read_data = count;
            CP0_REG_COMPARE:  bus.cp0_read_data = compare;
            CP0_REG_STATUS:   bus.cp0_read_data = status_q;
            CP0_REG_CAUSE:    bus.cp0_read_data = cause_q;
            CP0_REG_EPC:      bus.cp0_read_data = epc_q;
            default:          bus.cp0_read_data = '0;
        endcase
    end

    assign bus.cp0_status    = status_q;
    assign bus.cp0_cause     = cause_q;
    assign bus.cp0_epc       = epc_q;
    assign bus.cp0_count     = count;
    assign bus.cp0_compare   = compare;
    assign bus.cp0_bad_vaddr = badv_q;
    assign bus.timer_int     = pending;

endmodule

// File: tb/tb_cp0_register_file.sv
// Directed bench for cp0_register_file with hand-computed expectations.
module tb_cp0_register_file;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cp0_register_file_if bus ();

    cp0_register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_wb_cp0         = 1'b1;
        bus.wb_cp0_write_addr = addr;
        bus.wb_cp0_write      = data;
        tick();
        bus.wb_wb_cp0         = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.wb_wb_cp0         = 1'b0;
        bus.wb_cp0_write_addr = '0;
        bus.wb_cp0_write      = '0;
        bus.cp0_read_addr     = '0;
        bus.exc_valid         = 1'b0;
        bus.exc_code          = '0;
        bus.exc_pc            = '0;
        bus.exc_in_delay_slot = 1'b0;
        bus.exc_bad_vaddr     = '0;
        bus.eret              = 1'b0;
        bus.hw_int            = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_status", bus.cp0_status, 32'h0040_0000);
        check("rst_count", bus.cp0_count, 32'd0);

        repeat (10) tick();
        check("idle_status", bus.cp0_status, 32'h0040_0000);
        check("idle_count", bus.cp0_count, 32'd10);
        check("idle_cause", bus.cp0_cause, 32'd0);
        check("idle_epc", bus.cp0_epc, 32'd0);
        check("idle_timer", {31'd0, bus.timer_int}, 32'd0);

        // Write masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        check("status_mask", bus.cp0_status, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_mask", bus.cp0_cause, 32'h00C0_0300);
        bus.cp0_read_addr = 5'd12; #1;
        check("mfc0_status", bus.cp0_read_data, 32'h0040_FF03);
        bus.cp0_read_addr = 5'd13; #1;
        check("mfc0_cause", bus.cp0_read_data, 32'h00C0_0300);
        bus.cp0_read_addr = 5'd3; #1;
        check("mfc0_unimpl", bus.cp0_read_data, 32'd0);
        mtc0(5'd12, 32'h0040_0000);
        check("status_restore", bus.cp0_status, 32'h0040_0000);
        mtc0(5'd13, 32'd0);
        check("cause_clear", bus.cp0_cause, 32'd0);

        // Timer
        mtc0(5'd11, 32'h20);
        mtc0(5'd9, 32'h1E);
        check("tmr_count_load", bus.cp0_count, 32'h1E);
        check("tmr_t0", {31'd0, bus.timer_int}, 32'd0);
        tick();
        check("tmr_t1", {31'd0, bus.timer_int}, 32'd0);
        tick();
        check("tmr_count_match", bus.cp0_count, 32'h20);
        check("tmr_t2", {31'd0, bus.timer_int}, 32'd0);
        tick();
        check("tmr_rise", {31'd0, bus.timer_int}, 32'd1);
        check("tmr_cause_ip7", bus.cp0_cause, 32'h0000_8000);
        tick();
        tick();
        check("tmr_sticky_count", bus.cp0_count, 32'h23);
        check("tmr_sticky", {31'd0, bus.timer_int}, 32'd1);
        mtc0(5'd11, 32'h40);
        check("tmr_clear", {31'd0, bus.timer_int}, 32'd0);
        check("tmr_clear_cause", bus.cp0_cause, 32'd0);
        check("tmr_compare", bus.cp0_compare, 32'h40);

        // Exception in delay slot
        bus.exc_valid         = 1'b1;
        bus.exc_code          = 5'd4;
        bus.exc_pc            = 32'hBFC0_0100;
        bus.exc_in_delay_slot = 1'b1;
        bus.exc_bad_vaddr     = 32'h0000_1233;
        tick();
        check("exc1_epc", bus.cp0_epc, 32'hBFC0_00FC);
        check("exc1_cause", bus.cp0_cause, 32'h8000_0010);
        check("exc1_badv", bus.cp0_bad_vaddr, 32'h0000_1233);
        check("exc1_status", bus.cp0_status, 32'h0040_0002);

        // Nested exception
        bus.exc_code          = 5'd12;
        bus.exc_pc            = 32'h8000_0000;
        bus.exc_in_delay_slot = 1'b0;
        bus.exc_bad_vaddr     = 32'h0000_DEAD;
        tick();
        check("exc2_epc", bus.cp0_epc, 32'hBFC0_00FC);
        check("exc2_cause", bus.cp0_cause, 32'h8000_0030);
        check("exc2_badv", bus.cp0_bad_vaddr, 32'h0000_1233);
        bus.exc_valid = 1'b0;

        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        check("eret_status", bus.cp0_status, 32'h0040_0000);
        check("eret_cause", bus.cp0_cause, 32'h8000_0030);

        // MTC0 EPC together with an exception
        bus.wb_wb_cp0         = 1'b1;
        bus.wb_cp0_write_addr = 5'd14;
        bus.wb_cp0_write      = 32'h0000_1234;
        bus.exc_valid         = 1'b1;
        bus.exc_code          = 5'd8;
        bus.exc_pc            = 32'h0000_0400;
        tick();
        bus.wb_wb_cp0 = 1'b0;
        check("sim_epc", bus.cp0_epc, 32'h0000_0400);
        check("sim_cause", bus.cp0_cause, 32'h0000_0020);
        check("sim_status", bus.cp0_status, 32'h0040_0002);

        // Exception beats ERET
        bus.exc_code = 5'd9;
        bus.exc_pc   = 32'h0000_0500;
        bus.eret     = 1'b1;
        tick();
        bus.exc_valid = 1'b0;
        bus.eret      = 1'b0;
        check("exc_eret_status", bus.cp0_status, 32'h0040_0002);
        check("exc_eret_cause", bus.cp0_cause, 32'h0000_0024);
        check("exc_eret_epc", bus.cp0_epc, 32'h0000_0400);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        check("wrap_load", bus.cp0_count, 32'hFFFF_FFFF);
        tick();
        check("wrap_zero", bus.cp0_count, 32'd0);

        bus.hw_int = 6'b100001;
        tick();
        check("hwint_ip", {26'd0, bus.cp0_cause[15:10]}, 32'h21);
        check("hwint_cause", bus.cp0_cause, 32'h0000_8424);
        bus.cp0_read_addr = 5'd14; #1;
        check("mfc0_epc", bus.cp0_read_data, 32'h0000_0400);
        bus.cp0_read_addr = 5'd8; #1;
        check("mfc0_badv", bus.cp0_read_data, 32'h0000_1233);
        bus.cp0_read_addr = 5'd11; #1;
        check("mfc0_compare", bus.cp0_read_data, 32'h40);

        // Reset mid-run overrides concurrent activity
        rst                   = 1'b1;
        bus.wb_wb_cp0         = 1'b1;
        bus.wb_cp0_write_addr = 5'd14;
        bus.wb_cp0_write      = 32'h55;
        bus.exc_valid         = 1'b1;
        tick();
        rst           = 1'b0;
        bus.wb_wb_cp0 = 1'b0;
        bus.exc_valid = 1'b0;
        bus.hw_int    = '0;
        check("mrst_status", bus.cp0_status, 32'h0040_0000);
        check("mrst_cause", bus.cp0_cause, 32'd0);
        check("mrst_epc", bus.cp0_epc, 32'd0);
        check("mrst_count", bus.cp0_count, 32'd0);
        check("mrst_compare", bus.cp0_compare, 32'd0);
        check("mrst_badv", bus.cp0_bad_vaddr, 32'd0);
        check("mrst_timer", {31'd0, bus.timer_int}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
